// File: rtl/lunc_pkg.sv
// Shared character codes and filter state type for the lunc stream stages.
package lunc_pkg;

  localparam logic [7:0] ESC_CODE = 8'h1b;
  localparam logic [7:0] NUL_CODE = 8'h00;
  localparam logic [7:0] EOL_CODE = 8'h0a;

  typedef enum logic {
    PASS = 1'b0,
    SKIP = 1'b1
  } filt_state_t;

endpackage

// File: rtl/lunc_out_buffer_byte_fifo.sv
// First-word-fall-through synchronous FIFO; the head entry is always visible on rd_data.
module byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_pop_s;
  logic             do_push_s;

  assign do_pop_s  = pop && (count_r != {(AW+1){1'b0}});
  assign do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);

  // Storage and pointer/occupancy update; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;
  assign full    = (count_r == DEPTH_C);
  assign empty   = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/lunc_out_buffer.sv
// Output buffer: drops NUL fill and ESC command pairs, queues the rest for a line-oriented sink.
module lunc_out_buffer #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] ESC_CODE  = lunc_pkg::ESC_CODE,
  parameter logic [7:0] NUL_CODE  = lunc_pkg::NUL_CODE,
  parameter logic [7:0] EOL_CODE  = lunc_pkg::EOL_CODE,
  parameter bit         STRIP_ESC = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             dataIn,
  output logic [7:0]             outData,
  output logic                   outEol,
  output logic                   outValid,
  input  logic                   outReady,
  output logic                   lineAvail,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  import lunc_pkg::*;

  localparam int AW = $clog2(DEPTH);

  filt_state_t state_r;
  filt_state_t state_nxt_s;
  logic        keep_s;
  logic        pop_s;
  logic        push_s;
  logic        empty_s;
  logic [8:0]  head_s;
  logic [AW:0] line_cnt_r;
  logic        overflow_r;
  logic        line_inc_s;
  logic        line_dec_s;

  // Filter state register.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r <= PASS;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Filter decision: which incoming bytes are kept and when a command byte must be skipped.
  always_comb begin
    state_nxt_s = state_r;
    keep_s      = 1'b0;
    case (state_r)
      PASS: begin
        if (dataIn == NUL_CODE) begin
          keep_s = 1'b0;
        end else if (STRIP_ESC && (dataIn == ESC_CODE)) begin
          state_nxt_s = SKIP;
        end else begin
          keep_s = 1'b1;
        end
      end
      SKIP: begin
        state_nxt_s = PASS;
      end
      default: begin
        state_nxt_s = PASS;
      end
    endcase
  end

  assign pop_s      = !empty_s && outReady;
  assign push_s     = keep_s && (!full || pop_s);
  assign line_inc_s = push_s && (dataIn == EOL_CODE);
  assign line_dec_s = pop_s && head_s[8];

  // Count of stored EOL characters and the sticky overflow flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      line_cnt_r <= {(AW+1){1'b0}};
      overflow_r <= 1'b0;
    end else begin
      case ({line_inc_s, line_dec_s})
        2'b10:   line_cnt_r <= line_cnt_r + {{AW{1'b0}}, 1'b1};
        2'b01:   line_cnt_r <= line_cnt_r - {{AW{1'b0}}, 1'b1};
        default: line_cnt_r <= line_cnt_r;
      endcase
      if (keep_s && full && !pop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (9)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push_s),
    .pop     (pop_s),
    .wr_data ({(dataIn == EOL_CODE), dataIn}),
    .rd_data (head_s),
    .count   (count),
    .full    (full),
    .empty   (empty_s)
  );

  assign outData   = head_s[7:0];
  assign outEol    = head_s[8];
  assign outValid  = !empty_s;
  assign lineAvail = (line_cnt_r != {(AW+1){1'b0}});
  assign overflow  = overflow_r;

endmodule
